// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module : alarm_pkg
// Brief  : Shared types and cadence constants for the alarm buzzer path.
// Rev    : 1.0  initial release
// ============================================================================
package alarm_pkg;

  // Beeper cadence states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEEP  = 2'd1,
    GAP   = 2'd2,
    PAUSE = 2'd3
  } beeper_state_t;

  // Simulation-friendly cadence defaults
  localparam int c_tick_div_sim    = 4;
  localparam int c_tone_half_sim   = 2;
  localparam int c_beep_ticks      = 3;
  localparam int c_gap_ticks       = 2;
  localparam int c_beeps           = 2;
  localparam int c_pause_ticks     = 5;
  localparam int c_max_bursts      = 3;

  // Board values for a 50 MHz clock: 0.25 s cadence tick, 2 kHz tone
  localparam int c_tick_div_board  = 12500000;
  localparam int c_tone_half_board = 12500;

  // Bits needed to hold 0..max_val (at least one bit)
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/beep_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : beep_tick_gen
// Brief  : Clock-enable divider; tick is high for one clk every DIV cycles.
//          clr realigns the phase so the next tick lands DIV cycles later.
// Rev    : 1.0  initial release
// ============================================================================
module beep_tick_gen
  import alarm_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int             c_w    = cnt_width(DIV - 1);
  localparam logic [c_w-1:0] c_last = c_w'(DIV - 1);
  localparam logic [c_w-1:0] c_one  = c_w'(1);

  logic [c_w-1:0] r_cnt;

  // Free-running divider counter with explicit wrap and synchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/alarm_beeper.sv
`default_nettype none
// ============================================================================
// Module : alarm_beeper
// Brief  : Piezo buzzer driver. Square-wave tone in bursts of BEEPS beeps
//          separated by gaps, followed by a long pause, repeated until stop.
//          Optional macro BEEPER_TIMEOUT_EN: auto-stop after MAX_BURSTS
//          bursts with a one-cycle timed_out pulse.
// Rev    : 1.0  initial release
// ============================================================================
module alarm_beeper
  import alarm_pkg::*;
#(
  parameter int TICK_DIV    = c_tick_div_sim,
  parameter int TONE_HALF   = c_tone_half_sim,
  parameter int BEEP_TICKS  = c_beep_ticks,
  parameter int GAP_TICKS   = c_gap_ticks,
  parameter int BEEPS       = c_beeps,
  parameter int PAUSE_TICKS = c_pause_ticks,
  parameter int MAX_BURSTS  = c_max_bursts
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  output logic buzzer,
  output logic active,
  output logic timed_out
);

  localparam int c_phase_max0 = (BEEP_TICKS > GAP_TICKS) ? BEEP_TICKS : GAP_TICKS;
  localparam int c_phase_max  = (c_phase_max0 > PAUSE_TICKS) ? c_phase_max0 : PAUSE_TICKS;
  localparam int c_pw = cnt_width(c_phase_max - 1);
  localparam int c_tw = cnt_width(TONE_HALF - 1);
  localparam int c_bw = cnt_width(BEEPS - 1);

  localparam logic [c_pw-1:0] c_beep_last  = c_pw'(BEEP_TICKS - 1);
  localparam logic [c_pw-1:0] c_gap_last   = c_pw'(GAP_TICKS - 1);
  localparam logic [c_pw-1:0] c_pause_last = c_pw'(PAUSE_TICKS - 1);
  localparam logic [c_pw-1:0] c_phase_one  = c_pw'(1);
  localparam logic [c_tw-1:0] c_tone_last  = c_tw'(TONE_HALF - 1);
  localparam logic [c_tw-1:0] c_tone_one   = c_tw'(1);
  localparam logic [c_bw-1:0] c_beeps_last = c_bw'(BEEPS - 1);
  localparam logic [c_bw-1:0] c_beep_one   = c_bw'(1);

  beeper_state_t   r_state, w_state;
  logic [c_pw-1:0] r_phase, w_phase;
  logic [c_tw-1:0] r_tone, w_tone;
  logic [c_bw-1:0] r_beep_idx, w_beep_idx;
  logic            r_buzzer, w_buzzer;
  logic            r_active, w_active;
  logic            r_timed_out, w_timed_out;
  logic            w_tick, w_tick_clr;
  logic            w_last_burst;

`ifdef BEEPER_TIMEOUT_EN
  localparam int              c_uw         = cnt_width(MAX_BURSTS - 1);
  localparam logic [c_uw-1:0] c_burst_last = c_uw'(MAX_BURSTS - 1);
  localparam logic [c_uw-1:0] c_burst_one  = c_uw'(1);

  logic [c_uw-1:0] r_burst, w_burst;

  // Burst counter register, only present when auto-stop is built in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_burst <= '0;
    else        r_burst <= w_burst;
  end

  assign w_last_burst = (r_burst == c_burst_last);
`else
  assign w_last_burst = 1'b0;
`endif

  beep_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_tick_clr),
    .tick  (w_tick)
  );

  // State and output registers; reset forces silence without a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_tone      <= '0;
      r_beep_idx  <= '0;
      r_buzzer    <= 1'b0;
      r_active    <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_phase     <= w_phase;
      r_tone      <= w_tone;
      r_beep_idx  <= w_beep_idx;
      r_buzzer    <= w_buzzer;
      r_active    <= w_active;
      r_timed_out <= w_timed_out;
    end
  end

  // Next-state, counter and output decode; stop overrides everything
  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase;
    w_tone      = r_tone;
    w_beep_idx  = r_beep_idx;
    w_buzzer    = 1'b0;
    w_timed_out = 1'b0;
    w_tick_clr  = 1'b0;
`ifdef BEEPER_TIMEOUT_EN
    w_burst     = r_burst;
`endif
    if (stop) begin
      w_state    = IDLE;
      w_phase    = '0;
      w_tone     = '0;
      w_beep_idx = '0;
`ifdef BEEPER_TIMEOUT_EN
      w_burst    = '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state    = BEEP;
            w_phase    = '0;
            w_tone     = '0;
            w_beep_idx = '0;
            w_buzzer   = 1'b1;
            w_tick_clr = 1'b1;
`ifdef BEEPER_TIMEOUT_EN
            w_burst    = '0;
`endif
          end
        end
        BEEP: begin
          if (r_tone == c_tone_last) begin
            w_tone   = '0;
            w_buzzer = ~r_buzzer;
          end else begin
            w_tone   = r_tone + c_tone_one;
            w_buzzer = r_buzzer;
          end
          if (w_tick) begin
            if (r_phase == c_beep_last) begin
              w_phase  = '0;
              w_tone   = '0;
              w_buzzer = 1'b0;
              if (r_beep_idx != c_beeps_last) begin
                w_state = GAP;
              end else if (w_last_burst) begin
                w_state     = IDLE;
                w_beep_idx  = '0;
                w_timed_out = 1'b1;
`ifdef BEEPER_TIMEOUT_EN
                w_burst     = '0;
`endif
              end else begin
                w_state = PAUSE;
              end
            end else begin
              w_phase = r_phase + c_phase_one;
            end
          end
        end
        GAP: begin
          if (w_tick) begin
            if (r_phase == c_gap_last) begin
              w_state    = BEEP;
              w_phase    = '0;
              w_tone     = '0;
              w_beep_idx = r_beep_idx + c_beep_one;
              w_buzzer   = 1'b1;
            end else begin
              w_phase = r_phase + c_phase_one;
            end
          end
        end
        PAUSE: begin
          if (w_tick) begin
            if (r_phase == c_pause_last) begin
              w_state    = BEEP;
              w_phase    = '0;
              w_tone     = '0;
              w_beep_idx = '0;
              w_buzzer   = 1'b1;
`ifdef BEEPER_TIMEOUT_EN
              w_burst    = r_burst + c_burst_one;
`endif
            end else begin
              w_phase = r_phase + c_phase_one;
            end
          end
        end
        default: w_state = IDLE;
      endcase
    end
    w_active = (w_state != IDLE);
  end

  assign buzzer    = r_buzzer;
  assign active    = r_active;
  assign timed_out = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_alarm_beeper.sv
`default_nettype none
// ============================================================================
// Module : tb_alarm_beeper
// Brief  : Directed self-checking bench for alarm_beeper (default cadence).
// Rev    : 1.0  initial release
// ============================================================================
module tb_alarm_beeper;

  logic clk;
  logic rst_n;
  logic start;
  logic stop;
  logic buzzer;
  logic active;
  logic timed_out;

  int n_cmp = 0;
  int n_bad = 0;

  alarm_beeper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .buzzer    (buzzer),
    .active    (active),
    .timed_out (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected cadence, cycle c counted from 1 after the start edge.
  // One burst = 12 beep + 8 gap + 12 beep + 20 pause = 52 cycles.
  function automatic logic exp_buzz(input int c);
    int pos;
`ifdef BEEPER_TIMEOUT_EN
    if (c >= 137) return 1'b0;
`endif
    pos = (c - 1) % 52;
    if (pos < 12) return 1'(((pos / 2) % 2) == 0);
    if (pos < 20) return 1'b0;
    if (pos < 32) return 1'(((pos - 20) / 2 % 2) == 0);
    return 1'b0;
  endfunction

  function automatic logic exp_active(input int c);
`ifdef BEEPER_TIMEOUT_EN
    return 1'(c < 137);
`else
    return 1'(c >= 1);
`endif
  endfunction

  function automatic logic exp_to(input int c);
`ifdef BEEPER_TIMEOUT_EN
    return 1'(c == 137);
`else
    return 1'(c < 0);
`endif
  endfunction

  task automatic chk(input string tag, input int c, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start the alarm and follow the cadence; optionally inject ignored starts
  task automatic run_cadence(input int last_c, input bit extra);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      chk("buzzer", c, buzzer, exp_buzz(c));
      chk("active", c, active, exp_active(c));
      chk("timed_out", c, timed_out, exp_to(c));
      start = extra && (c == 5 || c == 15);
      step();
    end
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop  = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    #1;
    // Reset state before any clock edge
    chk("rst_buzzer", 0, buzzer, 1'b0);
    chk("rst_active", 0, active, 1'b0);
    chk("rst_timed_out", 0, timed_out, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Full cadence across several bursts (auto-stop point when enabled)
    run_cadence(160, 1'b0);

    // Stop at cycle 6, restart at cycle 10
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c <= 6) begin
        chk("s2_buzzer", c, buzzer, exp_buzz(c));
        chk("s2_active", c, active, 1'b1);
      end else if (c <= 10) begin
        chk("s2_buzzer", c, buzzer, 1'b0);
        chk("s2_active", c, active, 1'b0);
      end else begin
        chk("s2_buzzer", c, buzzer, exp_buzz(c - 10));
        chk("s2_active", c, active, 1'b1);
      end
      stop  = (c == 6);
      start = (c == 10);
      step();
    end
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop  = 1'b0;
    step();

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("s3_buzzer", c, buzzer, 1'b0);
      chk("s3_active", c, active, 1'b0);
      step();
    end

    // Extra start pulses while running are ignored
    run_cadence(60, 1'b1);

    // Asynchronous reset in the middle of cycle 8
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    chk("s5_pre_active", 8, active, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_buzzer", 8, buzzer, 1'b0);
    chk("s5_async_active", 8, active, 1'b0);
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      chk("s5_idle_buzzer", c, buzzer, 1'b0);
      chk("s5_idle_active", c, active, 1'b0);
      step();
    end
    // New start after reset follows normal timing
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("s5_restart_buzzer", c, buzzer, exp_buzz(c));
      chk("s5_restart_active", c, active, 1'b1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_beeper.md
Name: alarm_beeper

Overview:
Output-side counterpart to the pushbutton input conditioning. Drives the piezo buzzer pin with a square-wave tone in a burst cadence: N beeps separated by gaps, then a long pause, repeated. Started by the alarm-match pulse and stopped by a debounced button pulse (snooze/off). Single clock domain; all timing comes from an internal clock-enable tick, with no derived clocks.

Parameters:
TICK_DIV, 4, clk cycles per cadence tick (sim value; board build overrides to 12500000)
TONE_HALF, 2, clk cycles per half-period of tone square wave (board: 12500)
BEEP_TICKS, 3, ticks per beep (>=1)
GAP_TICKS, 2, ticks of silence between beeps in a burst (>=1)
BEEPS, 2, beeps per burst (>=1)
PAUSE_TICKS, 5, ticks of silence after each burst (>=1)
MAX_BURSTS, 3, bursts before auto-stop (used only with BEEPER_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin alarm
stop  in  1  single-cycle pulse from debouncer: silence alarm
buzzer  out  1  registered tone output to pin
active  out  1  high while not IDLE
timed_out  out  1  single-cycle pulse on auto-stop

Behaviour:
- Reset (async, rst_n=0): state IDLE; buzzer=0, active=0, timed_out=0; all counters 0.
- States: IDLE, BEEP, GAP, PAUSE. All outputs are registered.
- Tick: tick_cnt counts 0..TICK_DIV-1 and wraps; tick=1 when tick_cnt==TICK_DIV-1. tick_cnt is cleared when start is accepted, so phase boundaries are aligned.
- IDLE: start=1 and stop=0 -> BEEP at the next edge. Clear tick_cnt, phase_cnt, beep_idx, burst_cnt, tone_cnt. buzzer=1 from that edge. Latency: 1 cycle.
- BEEP: tone_cnt counts 0..TONE_HALF-1; buzzer toggles on wrap, giving period 2*TONE_HALF. On each tick phase_cnt++. At the tick where phase_cnt==BEEP_TICKS-1: go to GAP if beep_idx<BEEPS-1, else PAUSE. phase_cnt resets to 0 on every state change.
- GAP: buzzer=0. After GAP_TICKS ticks -> BEEP, beep_idx++, tone_cnt=0, buzzer=1.
- PAUSE: buzzer=0. After PAUSE_TICKS ticks -> BEEP, beep_idx=0, burst_cnt++.
- Each phase lasts exactly (ticks)*TICK_DIV clk cycles.
- stop=1 in any state -> IDLE at the next edge with buzzer=0, active=0. stop beats start when both are high.
- start while not IDLE: ignored. The cadence does not restart.
- Width rules: each counter is $clog2(max+1) bits. Counters never exceed their limit; wrap is explicit compare-and-clear.
- rst_n asserted mid-burst: immediate IDLE, buzzer=0 without waiting for a clock edge.

Optional Feature:
BEEPER_TIMEOUT_EN
- Defined: at the end of the last beep of burst MAX_BURSTS (the transition that would enter PAUSE with burst_cnt==MAX_BURSTS-1), go to IDLE instead. timed_out=1 for that one cycle. A stop on the same cycle still goes to IDLE but does not assert timed_out.
- Undefined: cadence repeats until stop. timed_out is tied 0. burst_cnt logic and MAX_BURSTS are unused.

Decomposition:
- alarm_pkg: beeper_state_t enum (IDLE, BEEP, GAP, PAUSE), default cadence constants, board TICK_DIV/TONE_HALF values.
- Sub-module beep_tick_gen: parameter DIV; inputs clk, rst_n, clr; output tick. This is the clock-enable divider, reusable by the debouncer path.

Test Plan:
1. Reset, then start pulse at edge 0 -> buzzer 1,1,0,0,1,1,0,0,1,1,0,0 (cycles 1-12); 0 for cycles 13-20 (GAP); same tone for cycles 21-32; 0 for cycles 33-52 (PAUSE); tone resumes at cycle 53. active=1 from cycle 1.
2. start, then stop pulse at cycle 6 -> buzzer=0, active=0 from cycle 7. A new start at cycle 10 restarts from scenario-1 cycle 1 timing.
3. start and stop high on the same cycle in IDLE -> remains IDLE, buzzer stays 0.
4. Extra start pulses at cycles 5 and 15 -> waveform identical to scenario 1.
5. rst_n low at cycle 8, async (mid-edge) -> buzzer=0 and active=0 immediately; stays IDLE after release until the next start.
6. With BEEPER_TIMEOUT_EN, defaults -> three bursts; at the end of the third burst's second beep, active falls and timed_out pulses for 1 cycle. Without the macro, a 4th burst begins and timed_out stays 0.
